sc_phase_sequencer: RTL



---
 rtl/sc_phase_pkg.sv | 41 ++++
 rtl/sc_cfg_shadow.sv | 54 +++++
 rtl/sc_phase_sequencer.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/sc_phase_pkg.sv
// Shared types and constants for the switched-capacitor phase sequencer.
package sc_phase_pkg;

   localparam int unsigned PKG_NCH   = 2;
   localparam int unsigned PKG_CNT_W = 8;
   localparam int unsigned PKG_CAP_W = 4;

   typedef enum logic [2:0] {
      IDLE,
      P1,
      D12,
      P2,
      D21
   } sc_state_e;

   localparam logic [PKG_CNT_W-1:0] DEF_P1   = PKG_CNT_W'(4);
   localparam logic [PKG_CNT_W-1:0] DEF_P2   = PKG_CNT_W'(4);
   localparam logic [PKG_CNT_W-1:0] DEF_DEAD = PKG_CNT_W'(1);

   typedef struct packed {
      logic [PKG_CNT_W-1:0] p1;
      logic [PKG_CNT_W-1:0] p2;
      logic [PKG_CNT_W-1:0] dead;
   } sc_timing_t;

   typedef struct packed {
      sc_timing_t                     tim;
      logic [PKG_NCH*PKG_CAP_W-1:0]   capsel;
   } sc_cfg_t;

   localparam sc_cfg_t DEF_CFG = '{
      tim:    '{p1: DEF_P1, p2: DEF_P2, dead: DEF_DEAD},
      capsel: '0
   };

   // A zero length still occupies one cycle so the non-overlap gap never vanishes.
   function automatic logic [PKG_CNT_W-1:0] eff_len(input logic [PKG_CNT_W-1:0] len);
      return (len == '0) ? PKG_CNT_W'(1) : len;
   endfunction

endpackage

// File: rtl/sc_cfg_shadow.sv
// Pending/active config register pair; pending is promoted to active only on apply_i.
module sc_cfg_shadow
   import sc_phase_pkg::*;
(
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           cfg_valid_i,
   input  sc_cfg_t                        cfg_i,
   input  logic                           apply_i,
   output logic                           cfg_ready_o,
   output logic [PKG_NCH*PKG_CAP_W-1:0]   capsel_o,
   output sc_timing_t                     tim_nxt_c
);

   sc_cfg_t pend_q, pend_d;
   sc_cfg_t act_q, act_d;
   logic    pend_vld_q, pend_vld_d;
   logic    ready_q;

   // Apply only consumes a config captured in an earlier cycle; accept only fills an empty slot.
   always_comb begin
      pend_d     = pend_q;
      pend_vld_d = pend_vld_q;
      act_d      = act_q;
      if (apply_i && pend_vld_q) begin
         act_d      = pend_q;
         pend_vld_d = 1'b0;
      end
      if (cfg_valid_i && !pend_vld_q) begin
         pend_d     = cfg_i;
         pend_vld_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pend_q     <= '0;
         pend_vld_q <= 1'b0;
         act_q      <= DEF_CFG;
         ready_q    <= 1'b1;
      end else begin
         pend_q     <= pend_d;
         pend_vld_q <= pend_vld_d;
         act_q      <= act_d;
         ready_q    <= ~pend_vld_d;
      end
   end

   assign cfg_ready_o = ready_q;
   assign capsel_o    = act_q.capsel;
   // Look-ahead timing so a phase entered on an apply edge loads the new length.
   assign tim_nxt_c   = act_d.tim;

endmodule

// File: rtl/sc_phase_sequencer.sv
// Non-overlapping phi1/phi2 sequencer for time-interleaved SC filter channels.
// Every phase output is a flop decoded from the next state, so outputs align with state_q.
module sc_phase_sequencer
   import sc_phase_pkg::*;
#(
   parameter int unsigned  NCH   = PKG_NCH,
   parameter int unsigned  CNT_W = PKG_CNT_W,
   parameter int unsigned  CAP_W = PKG_CAP_W,
   localparam int unsigned CH_W  = (NCH > 1) ? $clog2(NCH) : 1
)(
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   en,
   input  logic                   cfg_valid,
   output logic                   cfg_ready,
   input  logic [CNT_W-1:0]       cfg_p1_len,
   input  logic [CNT_W-1:0]       cfg_p2_len,
   input  logic [CNT_W-1:0]       cfg_dead,
   input  logic [NCH*CAP_W-1:0]   cfg_capsel,
   output logic [NCH-1:0]         phi1,
   output logic [NCH-1:0]         phi2,
   output logic [NCH-1:0]         phi1e,
   output logic [NCH*CAP_W-1:0]   capsel,
   output logic                   smp_strobe,
   output logic [CH_W-1:0]        smp_ch,
   output logic                   busy
);

   sc_cfg_t                       cfg_in_c;
   sc_timing_t                    tim_nxt_c;
   logic [PKG_NCH*PKG_CAP_W-1:0]  capsel_act;
   logic                          boundary_c;
   logic                          last_c;
   logic [CNT_W-1:0]              p1_len_c, p2_len_c, dead_len_c;

   sc_state_e         state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [CH_W-1:0]   ch_q, ch_d;
   logic [CH_W-1:0]   smp_ch_q, smp_ch_d;
   logic [NCH-1:0]    phi1_q, phi1_d;
   logic [NCH-1:0]    phi2_q, phi2_d;
   logic [NCH-1:0]    phi1e_q, phi1e_d;
   logic              smp_q, smp_d;
   logic              busy_q, busy_d;

   assign cfg_in_c = '{
      tim:    '{p1:   PKG_CNT_W'(cfg_p1_len),
                p2:   PKG_CNT_W'(cfg_p2_len),
                dead: PKG_CNT_W'(cfg_dead)},
      capsel: (PKG_NCH*PKG_CAP_W)'(cfg_capsel)
   };

   assign last_c     = (cnt_q <= CNT_W'(1));
   assign boundary_c = ((state_q == IDLE) && en) || ((state_q == D21) && last_c);

   sc_cfg_shadow u_shadow (
      .clk         (clk),
      .rst_n       (rst_n),
      .cfg_valid_i (cfg_valid),
      .cfg_i       (cfg_in_c),
      .apply_i     (boundary_c),
      .cfg_ready_o (cfg_ready),
      .capsel_o    (capsel_act),
      .tim_nxt_c   (tim_nxt_c)
   );

   assign p1_len_c   = CNT_W'(eff_len(tim_nxt_c.p1));
   assign p2_len_c   = CNT_W'(eff_len(tim_nxt_c.p2));
   assign dead_len_c = CNT_W'(eff_len(tim_nxt_c.dead));

   // State/counter advance, then phase decode from the next state.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      ch_d     = ch_q;
      phi1_d   = '0;
      phi2_d   = '0;
      phi1e_d  = '0;
      unique case (state_q)
         IDLE: begin
            if (en) begin
               state_d = P1;
               cnt_d   = p1_len_c;
            end
         end
         P1: begin
            if (last_c) begin
               state_d = D12;
               cnt_d   = dead_len_c;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         D12: begin
            if (last_c) begin
               state_d = P2;
               cnt_d   = p2_len_c;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         P2: begin
            if (last_c) begin
               state_d = D21;
               cnt_d   = dead_len_c;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         D21: begin
            if (last_c) begin
               ch_d    = (ch_q == CH_W'(NCH - 1)) ? '0 : ch_q + CH_W'(1);
               state_d = en ? P1 : IDLE;
               cnt_d   = p1_len_c;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (state_d == P1) begin
         phi1_d = NCH'(1) << ch_d;
         if (cnt_d != CNT_W'(1)) begin
            phi1e_d = NCH'(1) << ch_d;
         end
      end
      if (state_d == P2) begin
         phi2_d = NCH'(1) << ch_d;
      end
      smp_d    = (state_q == P2) && (state_d == D21);
      smp_ch_d = smp_d ? ch_q : smp_ch_q;
      busy_d   = (state_d != IDLE);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         cnt_q    <= CNT_W'(1);
         ch_q     <= '0;
         smp_ch_q <= '0;
         phi1_q   <= '0;
         phi2_q   <= '0;
         phi1e_q  <= '0;
         smp_q    <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         ch_q     <= ch_d;
         smp_ch_q <= smp_ch_d;
         phi1_q   <= phi1_d;
         phi2_q   <= phi2_d;
         phi1e_q  <= phi1e_d;
         smp_q    <= smp_d;
         busy_q   <= busy_d;
      end
   end

   assign phi1       = phi1_q;
   assign phi2       = phi2_q;
   assign phi1e      = phi1e_q;
   assign smp_strobe = smp_q;
   assign smp_ch     = smp_ch_q;
   assign busy       = busy_q;
   assign capsel     = (NCH*CAP_W)'(capsel_act);

endmodule
